chatter_filter_multi: RTL and testbench
=======================================

Name: chatter_filter_multi

Overview:
- Multi-channel, parametrised switch debouncer. Successor to the single-switch 1 ms OR-filter.
- Synchronises CH raw switch inputs and samples them on a shared programmable tick into per-channel DEPTH-deep shift histories.
- Produces a filtered level per channel using a selectable mode (OR / AND / hysteresis), plus one-clock rise and fall pulses.
- Sits between board switch/push-button pins and the control logic; outputs are clean and synchronous to clock.

Parameters:
- CH, 4, number of independent switch channels (>=1)
- CLK_PER_TICK, 50000, clocks per sample tick (50000 = 1 ms at 50 MHz; >=2)
- DEPTH, 4, samples held per channel (>=2)
- MODE, 0, filter function: 0 = OR of history (legacy), 1 = AND of history, 2 = hysteresis; value 3 behaves as 0

Ports:
- clock  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous active-low reset
- SW  input  CH  raw switch levels, asynchronous to clock
- SSW  output  CH  filtered switch levels
- RISE  output  CH  one-clock pulse when SSW[i] goes 0->1
- FALL  output  CH  one-clock pulse when SSW[i] goes 1->0
- TICK  output  1  one-clock pulse on each sample tick

Behaviour:
- Reset: reset_n low asynchronously clears the following, and they hold while reset_n is low:
  - tick counter
  - both synchroniser stages
  - all history registers
  - SSW, RISE, FALL, TICK all go to 0
- Synchroniser: 2-flop per channel. SYNC = SW delayed 2 clocks.
- Tick counter:
  - Width ceil(log2(CLK_PER_TICK)). Free-running 0..CLK_PER_TICK-1, then wraps to 0.
  - TICK (registered) is 1 in the clock following counter == CLK_PER_TICK-1.
  - After reset release, the first TICK appears CLK_PER_TICK clocks later.
  - Shared by all channels.
- History: on the clock where the counter reaches CLK_PER_TICK-1, HIST[i] <= {HIST[i][DEPTH-2:0], SYNC[i]}. HIST is held otherwise.
- Filter function F[i] (combinational from HIST[i]):
  - MODE 0: F = OR(HIST[i]).
  - MODE 1: F = AND(HIST[i]).
  - MODE 2: F = 1 if all ones; 0 if all zeros; otherwise current SSW[i] (hold).
- SSW[i] <= F[i] every clock. This is registered, so SSW updates in the same cycle TICK is high (one clock after the HIST shift).
- RISE[i] = 1 for exactly the one clock in which SSW[i] first shows the new 1; FALL[i] likewise for 0. Both are registered and aligned with the SSW change.
- RISE and FALL for one channel are never both high. Multiple channels may pulse in the same clock.
- Latency from an SW edge to the SSW change:
  - MODE 0 rise / MODE 1 fall: 2 sync clocks + wait to next tick + 1 clock.
  - MODE 0 fall / MODE 1 rise / MODE 2 either edge: DEPTH ticks of the stable level are needed.
- Glitch handling:
  - MODE 0: a glitch caught by a single tick stretches SSW high for exactly DEPTH ticks.
  - MODE 1 and MODE 2: that glitch is rejected.
- Reset mid-operation: outputs drop to 0 immediately. No FALL is generated by reset or by reset release. After release, history refills from zero.
- SW changes between ticks are ignored. Only the synchronised value at the tick clock is sampled.

Test Plan:
- Common bench settings: CH=4, CLK_PER_TICK=10, DEPTH=4 unless stated.
- Reset and tick:
  - Stimulus: hold reset_n=0 with SW=4'b1111; then release.
  - Required: SSW=0, RISE=FALL=TICK=0 during reset; first TICK exactly 10 clocks after release, then every 10 clocks.
- MODE=0 glitch:
  - Stimulus: SW[0]=1 for 10 clocks spanning one tick, else 0.
  - Required: SSW[0] high for exactly 40 clocks; one RISE[0] pulse and one FALL[0] pulse, each aligned to TICK.
- MODE=1 bounce:
  - Stimulus: SW[1] sampled 1,0,1,1,1,1 on successive ticks.
  - Required: SSW[1] rises at the 6th tick only, with one RISE[1]; the first 0 sample afterwards drops SSW[1] with one FALL[1].
- MODE=2 hysteresis:
  - Stimulus: SW[2]=1 for 4 ticks, then alternating 0/1 per tick for 8 ticks, then 0 for 4 ticks.
  - Required: SSW[2]=1 after the 4th tick; no FALL during the alternation; exactly one FALL[2] after the 4th zero tick.
- Channel independence (MODE=0):
  - Stimulus: SW=4'b1010 steady from reset.
  - Required: SSW=4'b1010 at the first tick after sync; RISE[1] and RISE[3] pulse in the same clock; RISE[0], RISE[2] and FALL stay 0.
- Reset mid-operation:
  - Stimulus: SSW=4'b1111, then pulse reset_n low for 3 clocks with SW held 4'b1111.
  - Required: SSW=0 immediately with no FALL pulses; after release, RISE pulses on all 4 channels at the first tick (MODE=0) or the 4th tick (MODE=1).

Source files
------------

// File: rtl/chatter_filter_multi.sv
// Multi-channel switch debouncer: 2-flop sync, shared sample tick, per-channel
// DEPTH-deep history filtered by OR / AND / hysteresis, with rise/fall pulses.
module chatter_filter_multi #(
  parameter int CH           = 4,
  parameter int CLK_PER_TICK = 50000,
  parameter int DEPTH        = 4,
  parameter int MODE         = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [CH-1:0] SW,
  output logic [CH-1:0] SSW,
  output logic [CH-1:0] RISE,
  output logic [CH-1:0] FALL,
  output logic          TICK
);

  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_TICK - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLK_PER_TICK - 2);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;
  logic [CH-1:0] r_ssw;
  logic [CH-1:0] r_rise;
  logic [CH-1:0] r_fall;
  logic [CH-1:0] w_f;
  logic          w_wrap;
  logic          w_shift;

  assign w_wrap  = (r_cnt == CNT_LAST);
  // History shifts on the edge that brings the counter to its last value, so the
  // filtered level lands in the same cycle as the registered TICK.
  assign w_shift = (r_cnt == CNT_PRE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SW;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [DEPTH-1:0] r_hist;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_hist <= '0;
        end else if (w_shift) begin
          r_hist <= {r_hist[DEPTH-2:0], r_sync2[gi]};
        end
      end

      // Mixed history keeps the current output in hysteresis mode.
      if (MODE == 1) begin : g_and
        assign w_f[gi] = &r_hist;
      end else if (MODE == 2) begin : g_hyst
        assign w_f[gi] = (&r_hist) | ((|r_hist) & r_ssw[gi]);
      end else begin : g_or
        assign w_f[gi] = |r_hist;
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ssw  <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_ssw  <= w_f;
      r_rise <= w_f & ~r_ssw;
      r_fall <= ~w_f & r_ssw;
    end
  end

  assign SSW  = r_ssw;
  assign RISE = r_rise;
  assign FALL = r_fall;
  assign TICK = r_tick;

endmodule

// File: tb/tb_chatter_filter_multi.sv
// Bench for chatter_filter_multi: three instances (OR / AND / hysteresis) share
// stimulus and are checked every clock against a sample-list reference model.
module tb_chatter_filter_multi;

  localparam int CH    = 4;
  localparam int P     = 10;
  localparam int DEPTH = 4;

  logic          clock;
  logic          reset_n;
  logic [CH-1:0] SW;
  logic [CH-1:0] ssw0, rise0, fall0, ssw1, rise1, fall1, ssw2, rise2, fall2;
  logic          tick0, tick1, tick2;

  logic [CH-1:0] d_ssw  [3];
  logic [CH-1:0] d_rise [3];
  logic [CH-1:0] d_fall [3];
  logic          d_tick [3];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int            n;
  logic [CH-1:0] swq [$];
  logic [CH-1:0] smp [$];
  logic [CH-1:0] e_ssw  [3];
  logic [CH-1:0] e_rise [3];
  logic [CH-1:0] e_fall [3];
  logic          e_tick;

  chatter_filter_multi #(.CH(CH), .CLK_PER_TICK(P), .DEPTH(DEPTH), .MODE(0)) u_m0 (
    .clock(clock), .reset_n(reset_n), .SW(SW),
    .SSW(ssw0), .RISE(rise0), .FALL(fall0), .TICK(tick0));
  chatter_filter_multi #(.CH(CH), .CLK_PER_TICK(P), .DEPTH(DEPTH), .MODE(1)) u_m1 (
    .clock(clock), .reset_n(reset_n), .SW(SW),
    .SSW(ssw1), .RISE(rise1), .FALL(fall1), .TICK(tick1));
  chatter_filter_multi #(.CH(CH), .CLK_PER_TICK(P), .DEPTH(DEPTH), .MODE(2)) u_m2 (
    .clock(clock), .reset_n(reset_n), .SW(SW),
    .SSW(ssw2), .RISE(rise2), .FALL(fall2), .TICK(tick2));

  assign d_ssw[0] = ssw0;  assign d_rise[0] = rise0;  assign d_fall[0] = fall0;  assign d_tick[0] = tick0;
  assign d_ssw[1] = ssw1;  assign d_rise[1] = rise1;  assign d_fall[1] = fall1;  assign d_tick[1] = tick1;
  assign d_ssw[2] = ssw2;  assign d_rise[2] = rise2;  assign d_fall[2] = fall2;  assign d_tick[2] = tick2;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    n = 0;
    swq = {};
    repeat (3) swq.push_back('0);
    smp = {};
    for (int m = 0; m < 3; m++) begin
      e_ssw[m] = '0; e_rise[m] = '0; e_fall[m] = '0;
    end
    e_tick = 1'b0;
  endtask

  // One clock edge: sample list is the SW seen 3 edges before each tick edge,
  // filter rules applied directly to the last DEPTH samples.
  task automatic model_edge();
    logic nv [3];
    if (reset_n) begin
      n++;
      swq.push_back(SW);
      while (swq.size() > 4) void'(swq.pop_front());
      e_tick = ((n % P) == 0);
      for (int m = 0; m < 3; m++) begin
        e_rise[m] = '0; e_fall[m] = '0;
      end
      if (e_tick) begin
        smp.push_back(swq[0]);
        while (smp.size() > DEPTH) void'(smp.pop_front());
        for (int c = 0; c < CH; c++) begin
          int ones;
          ones = 0;
          for (int j = 0; j < smp.size(); j++) ones += int'(smp[j][c]);
          nv[0] = (ones != 0);
          nv[1] = (ones == DEPTH);
          nv[2] = (ones == DEPTH) ? 1'b1 : ((ones == 0) ? 1'b0 : e_ssw[2][c]);
          for (int m = 0; m < 3; m++) begin
            e_rise[m][c] = nv[m] & ~e_ssw[m][c];
            e_fall[m][c] = ~nv[m] & e_ssw[m][c];
            e_ssw[m][c]  = nv[m];
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    int first_tick, n_ticks;
    first_tick = -1;
    n_ticks = 0;
    reset_n = 1'b0;
    SW = 4'b1111;
    model_reset();
    repeat (5) begin
      cyc();
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== '0) begin
          n_fail++;
          $display("FAIL reset_hold mode%0d got ssw=%b rise=%b fall=%b tick=%b exp all zero",
                   m, d_ssw[m], d_rise[m], d_fall[m], d_tick[m]);
        end
      end
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      cyc();
      if (d_tick[0]) begin
        n_ticks++;
        if (first_tick < 0) first_tick = i;
      end
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== {e_ssw[m], e_rise[m], e_fall[m], e_tick}) begin
          n_fail++;
          $display("FAIL reset_run mode%0d cyc=%0d got ssw=%b rise=%b fall=%b tick=%b exp ssw=%b rise=%b fall=%b tick=%b",
                   m, n, d_ssw[m], d_rise[m], d_fall[m], d_tick[m], e_ssw[m], e_rise[m], e_fall[m], e_tick);
        end
      end
    end
    n_cmp++;
    if (first_tick !== 10) begin
      n_fail++;
      $display("FAIL first_tick got %0d exp 10", first_tick);
    end
    n_cmp++;
    if (n_ticks !== 3) begin
      n_fail++;
      $display("FAIL tick_count got %0d exp 3", n_ticks);
    end
    $display("test_reset: first tick at clock %0d, %0d ticks in 35 clocks", first_tick, n_ticks);
  endtask

  task automatic test_mode0_glitch();
    int hi0, rises, falls, misalign, hi_other;
    hi0 = 0; rises = 0; falls = 0; misalign = 0; hi_other = 0;
    for (int i = 0; i < 130; i++) begin
      SW = (i >= 50 && i < 60) ? 4'b0001 : 4'b0000;
      cyc();
      if (i >= 50) begin
        hi0      += int'(d_ssw[0][0]);
        rises    += int'(d_rise[0][0]);
        falls    += int'(d_fall[0][0]);
        hi_other += int'(d_ssw[1][0]) + int'(d_ssw[2][0]);
        if ((d_rise[0][0] || d_fall[0][0]) && !d_tick[0]) misalign++;
      end
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== {e_ssw[m], e_rise[m], e_fall[m], e_tick}) begin
          n_fail++;
          $display("FAIL glitch mode%0d cyc=%0d got ssw=%b rise=%b fall=%b tick=%b exp ssw=%b rise=%b fall=%b tick=%b",
                   m, n, d_ssw[m], d_rise[m], d_fall[m], d_tick[m], e_ssw[m], e_rise[m], e_fall[m], e_tick);
        end
      end
    end
    n_cmp++;
    if (hi0 !== 40) begin n_fail++; $display("FAIL glitch_width got %0d clocks exp 40", hi0); end
    n_cmp++;
    if (rises !== 1 || falls !== 1) begin
      n_fail++; $display("FAIL glitch_pulses got rise=%0d fall=%0d exp 1/1", rises, falls);
    end
    n_cmp++;
    if (misalign !== 0) begin n_fail++; $display("FAIL glitch_align got %0d off-tick pulses exp 0", misalign); end
    n_cmp++;
    if (hi_other !== 0) begin n_fail++; $display("FAIL glitch_reject got %0d high clocks in AND/hyst exp 0", hi_other); end
    $display("test_mode0_glitch: OR high %0d clocks, rise %0d fall %0d", hi0, rises, falls);
  endtask

  // Drives one SW bit with one value per tick window; records tick index of pulses.
  task automatic run_tick_seq(input int ch, input int mode, input string tag,
                              input logic seq [], output int rise_t, output int fall_t,
                              output int rises, output int falls, output int fall_pos);
    int t;
    bit found;
    t = 0; rise_t = -1; fall_t = -1; rises = 0; falls = 0; fall_pos = 0;
    found = 0;
    SW = '0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      if (d_tick[0]) found = 1;
    end
    n_cmp++;
    if (!found) begin n_fail++; $display("FAIL %s_align got no tick in 12 clocks exp tick", tag); end
    for (int s = 0; s < seq.size(); s++) begin
      SW = '0;
      SW[ch] = seq[s];
      repeat (P) begin
        cyc();
        if (d_tick[0]) t++;
        if (d_rise[mode][ch]) begin rises++; rise_t = t; end
        if (d_fall[mode][ch]) begin falls++; fall_t = t; fall_pos = s; end
        for (int m = 0; m < 3; m++) begin
          n_cmp++;
          if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== {e_ssw[m], e_rise[m], e_fall[m], e_tick}) begin
            n_fail++;
            $display("FAIL %s mode%0d cyc=%0d got ssw=%b rise=%b fall=%b tick=%b exp ssw=%b rise=%b fall=%b tick=%b",
                     tag, m, n, d_ssw[m], d_rise[m], d_fall[m], d_tick[m], e_ssw[m], e_rise[m], e_fall[m], e_tick);
          end
        end
      end
    end
  endtask

  task automatic test_mode1_bounce();
    logic seq [];
    int rt, ft, rs, fs, fp;
    seq = new[8];
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run_tick_seq(1, 1, "bounce", seq, rt, ft, rs, fs, fp);
    n_cmp++;
    if (rt !== 6 || rs !== 1) begin n_fail++; $display("FAIL bounce_rise got tick %0d count %0d exp tick 6 count 1", rt, rs); end
    n_cmp++;
    if (ft !== 7 || fs !== 1) begin n_fail++; $display("FAIL bounce_fall got tick %0d count %0d exp tick 7 count 1", ft, fs); end
    $display("test_mode1_bounce: AND rise at tick %0d, fall at tick %0d", rt, ft);
  endtask

  task automatic test_mode2_hyst();
    logic seq [];
    int rt, ft, rs, fs, fp;
    seq = new[16];
    seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    run_tick_seq(2, 2, "hyst", seq, rt, ft, rs, fs, fp);
    n_cmp++;
    if (rt !== 4 || rs !== 1) begin n_fail++; $display("FAIL hyst_rise got tick %0d count %0d exp tick 4 count 1", rt, rs); end
    n_cmp++;
    if (ft !== 16 || fs !== 1) begin n_fail++; $display("FAIL hyst_fall got tick %0d count %0d exp tick 16 count 1", ft, fs); end
    $display("test_mode2_hyst: hysteresis rise at tick %0d, fall at tick %0d", rt, ft);
  endtask

  task automatic test_independence();
    int rc, bad;
    logic [CH-1:0] rv;
    rc = -1; bad = 0; rv = '0;
    SW = 4'b1010;
    reset_n = 1'b0;
    model_reset();
    repeat (3) cyc();
    reset_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (d_rise[0] != '0) begin
        if (rc < 0) begin rc = i; rv = d_rise[0]; end
        else bad++;
      end
      if (d_fall[0] != '0) bad++;
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== {e_ssw[m], e_rise[m], e_fall[m], e_tick}) begin
          n_fail++;
          $display("FAIL indep mode%0d cyc=%0d got ssw=%b rise=%b fall=%b tick=%b exp ssw=%b rise=%b fall=%b tick=%b",
                   m, n, d_ssw[m], d_rise[m], d_fall[m], d_tick[m], e_ssw[m], e_rise[m], e_fall[m], e_tick);
        end
      end
    end
    n_cmp++;
    if (rc !== 10 || rv !== 4'b1010) begin
      n_fail++; $display("FAIL indep_rise got clock %0d value %b exp clock 10 value 1010", rc, rv);
    end
    n_cmp++;
    if (bad !== 0 || ssw0 !== 4'b1010) begin
      n_fail++; $display("FAIL indep_steady got extra=%0d ssw=%b exp extra=0 ssw=1010", bad, ssw0);
    end
    $display("test_independence: RISE=%b at clock %0d", rv, rc);
  endtask

  task automatic test_reset_mid();
    int            fr [3];
    logic [CH-1:0] fv [3];
    SW = 4'b1111;
    repeat (60) cyc();
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if (d_ssw[m] !== 4'b1111) begin n_fail++; $display("FAIL midrst_pre mode%0d got ssw=%b exp 1111", m, d_ssw[m]); end
      fr[m] = -1; fv[m] = '0;
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 3; m++) begin
      n_cmp++;
      if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== '0) begin
        n_fail++;
        $display("FAIL midrst_async mode%0d got ssw=%b rise=%b fall=%b tick=%b exp all zero",
                 m, d_ssw[m], d_rise[m], d_fall[m], d_tick[m]);
      end
    end
    for (int i = 1; i <= 53; i++) begin
      if (i == 4) reset_n = 1'b1;
      cyc();
      for (int m = 0; m < 3; m++) begin
        if (d_rise[m] != '0 && fr[m] < 0) begin fr[m] = i - 3; fv[m] = d_rise[m]; end
        n_cmp++;
        if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== {e_ssw[m], e_rise[m], e_fall[m], e_tick}) begin
          n_fail++;
          $display("FAIL midrst mode%0d cyc=%0d got ssw=%b rise=%b fall=%b tick=%b exp ssw=%b rise=%b fall=%b tick=%b",
                   m, n, d_ssw[m], d_rise[m], d_fall[m], d_tick[m], e_ssw[m], e_rise[m], e_fall[m], e_tick);
        end
      end
    end
    n_cmp++;
    if (fr[0] !== 10 || fv[0] !== 4'b1111) begin n_fail++; $display("FAIL midrst_or got clock %0d value %b exp 10 1111", fr[0], fv[0]); end
    n_cmp++;
    if (fr[1] !== 40 || fv[1] !== 4'b1111) begin n_fail++; $display("FAIL midrst_and got clock %0d value %b exp 40 1111", fr[1], fv[1]); end
    n_cmp++;
    if (fr[2] !== 40 || fv[2] !== 4'b1111) begin n_fail++; $display("FAIL midrst_hyst got clock %0d value %b exp 40 1111", fr[2], fv[2]); end
    $display("test_reset_mid: first RISE after release at clocks %0d/%0d/%0d", fr[0], fr[1], fr[2]);
  endtask

  task automatic test_random();
    int resets, clocks;
    resets = 0; clocks = 0;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        resets++;
        reset_n = 1'b0;
        model_reset();
        repeat ($urandom_range(1, 3)) cyc();
        reset_n = 1'b1;
      end
      SW = CH'($urandom);
      repeat ($urandom_range(1, 35)) begin
        cyc();
        clocks++;
        for (int m = 0; m < 3; m++) begin
          n_cmp++;
          if ({d_ssw[m], d_rise[m], d_fall[m], d_tick[m]} !== {e_ssw[m], e_rise[m], e_fall[m], e_tick}) begin
            n_fail++;
            $display("FAIL random mode%0d cyc=%0d got ssw=%b rise=%b fall=%b tick=%b exp ssw=%b rise=%b fall=%b tick=%b",
                     m, n, d_ssw[m], d_rise[m], d_fall[m], d_tick[m], e_ssw[m], e_rise[m], e_fall[m], e_tick);
          end
        end
      end
    end
    $display("test_random: %0d clocks, %0d reset pulses", clocks, resets);
  endtask

  initial begin
    reset_n = 1'b0;
    SW = '0;
    model_reset();
    test_reset();
    test_mode0_glitch();
    test_mode1_bounce();
    test_mode2_hyst();
    test_independence();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
